// File: rtl/score_bcd_conv.sv
// score_bcd_conv
//   Iterative binary-to-BCD converter (shift-add-3 / double dabble) feeding
//   the per-digit seven-segment decoders. One bit is consumed per clock, so
//   a conversion takes BIN_W SHIFT cycles plus one DONE cycle. Leading zero
//   digits can be replaced by 4'hF, which the decoders render as blank.
//
// Ports
//   iCLK    system clock, rising edge
//   iRST_N  asynchronous active-low reset
//   iSTART  conversion request, honoured only in IDLE
//   iBIN    unsigned binary value, captured when iSTART is accepted
//   oBUSY   high while converting (SHIFT or DONE)
//   oDONE   one-cycle pulse when oBCD/oOVF update
//   oBCD    digit k at [4k+3:4k], digit 0 least significant
//   oOVF    last value did not fit in DIGITS digits (oBCD then all 9s)
module score_bcd_conv #(
    parameter int BIN_W    = 16,
    parameter int DIGITS   = 5,
    parameter int BLANK_LZ = 1
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iSTART,
    input  logic [BIN_W-1:0]      iBIN,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic [4*DIGITS-1:0]   oBCD,
    output logic                  oOVF
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Converted form of zero: digit 0 shows 0, the rest blank if enabled.
    function automatic logic [4*DIGITS-1:0] zeroDisplay();
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            if (BLANK_LZ != 0) r[4*k +: 4] = 4'hF;
        end
        return r;
    endfunction

    localparam logic [4*DIGITS-1:0] RESET_BCD = zeroDisplay();

    logic [1:0]          state;
    logic [BIN_W-1:0]    binReg;
    logic [4*DIGITS-1:0] scratch;
    logic [CNT_W-1:0]    cnt;
    logic                ovfSticky;

    logic [4*DIGITS-1:0] adjusted;
    logic [4*DIGITS-1:0] nextScratch;
    logic                topOut;
    logic [4*DIGITS-1:0] finalBcd;
    logic                leading;

    // Add-3 correction on every digit, then one-bit shift of {scratch, bin}.
    always_comb begin
        adjusted = scratch;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5)
                adjusted[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
        {topOut, nextScratch} = {adjusted, binReg[BIN_W-1]};
    end

    // Result formatting: saturate to all 9s on overflow, otherwise blank
    // zeros from the top until the first non-zero digit (digit 0 never).
    always_comb begin
        finalBcd = scratch;
        leading  = 1'b1;
        if (ovfSticky) begin
            for (int unsigned k = 0; k < DIGITS; k++)
                finalBcd[4*k +: 4] = 4'd9;
        end else begin
            for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
                if (leading && (scratch[4*k +: 4] == 4'd0)) begin
                    if (BLANK_LZ != 0) finalBcd[4*k +: 4] = 4'hF;
                end else begin
                    leading = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= IDLE;
            binReg    <= '0;
            scratch   <= '0;
            cnt       <= '0;
            ovfSticky <= 1'b0;
            oDONE     <= 1'b0;
            oOVF      <= 1'b0;
            oBCD      <= RESET_BCD;
        end else begin
            oDONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (iSTART) begin
                        binReg    <= iBIN;
                        scratch   <= '0;
                        ovfSticky <= 1'b0;
                        cnt       <= CNT_W'(BIN_W);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= nextScratch;
                    binReg    <= binReg << 1;
                    ovfSticky <= ovfSticky | topOut;
                    cnt       <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= DONE;
                end
                DONE: begin
                    oBCD  <= finalBcd;
                    oOVF  <= ovfSticky;
                    oDONE <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oBUSY = (state == SHIFT) || (state == DONE);

endmodule

// File: tb/tb_score_bcd_conv.sv
module tb_score_bcd_conv;

    logic        clk;
    logic        rstN;
    logic        iStart;
    logic [15:0] iBin;

    logic        busy0, done0, ovf0;
    logic [19:0] bcd0;
    logic        busy1, done1, ovf1;
    logic [19:0] bcd1;
    logic        busy2, done2, ovf2;
    logic [15:0] bcd2;

    int total = 0;
    int bad   = 0;

    score_bcd_conv #(.BIN_W(16), .DIGITS(5), .BLANK_LZ(1)) u0 (
        .iCLK(clk), .iRST_N(rstN), .iSTART(iStart), .iBIN(iBin),
        .oBUSY(busy0), .oDONE(done0), .oBCD(bcd0), .oOVF(ovf0));

    score_bcd_conv #(.BIN_W(16), .DIGITS(5), .BLANK_LZ(0)) u1 (
        .iCLK(clk), .iRST_N(rstN), .iSTART(iStart), .iBIN(iBin),
        .oBUSY(busy1), .oDONE(done1), .oBCD(bcd1), .oOVF(ovf1));

    score_bcd_conv #(.BIN_W(16), .DIGITS(4), .BLANK_LZ(1)) u2 (
        .iCLK(clk), .iRST_N(rstN), .iSTART(iStart), .iBIN(iBin),
        .oBUSY(busy2), .oDONE(done2), .oBCD(bcd2), .oOVF(ovf2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned p = 1;
        for (int unsigned i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Decimal display of v with nd digits: all 9s if it does not fit,
    // otherwise digit k blanked (F) when v < 10^k and blanking is on.
    function automatic logic [31:0] refBcd(input int unsigned v, input int unsigned nd, input bit blank);
        logic [31:0] r = '0;
        if (v >= pow10(nd)) begin
            for (int unsigned k = 0; k < nd; k++) r[4*k +: 4] = 4'd9;
        end else begin
            for (int unsigned k = 0; k < nd; k++) begin
                if (blank && k > 0 && v < pow10(k)) r[4*k +: 4] = 4'hF;
                else r[4*k +: 4] = 4'((v / pow10(k)) % 10);
            end
        end
        return r;
    endfunction

    task automatic checkResults(input int unsigned v);
        checkVal("bcd_d5_blank",   32'(bcd0), refBcd(v, 5, 1'b1));
        checkVal("ovf_d5_blank",   32'(ovf0), 32'(v >= 100000));
        checkVal("bcd_d5_noblank", 32'(bcd1), refBcd(v, 5, 1'b0));
        checkVal("ovf_d5_noblank", 32'(ovf1), 32'(v >= 100000));
        checkVal("bcd_d4_blank",   32'(bcd2), refBcd(v, 4, 1'b1));
        checkVal("ovf_d4_blank",   32'(ovf2), 32'(v >= 10000));
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, "_bcd0"}, 32'(bcd0), 32'h000FFFF0);
        checkVal({tag, "_bcd1"}, 32'(bcd1), 32'h00000000);
        checkVal({tag, "_bcd2"}, 32'(bcd2), 32'h0000FFF0);
        checkVal({tag, "_flags"}, {26'd0, busy0, done0, ovf0, busy1, done1, ovf1}, 32'd0);
        checkVal({tag, "_flags2"}, {29'd0, busy2, done2, ovf2}, 32'd0);
    endtask

    // Drive iSTART for exactly one rising edge; returns #1 after that edge.
    task automatic startPulse(input logic [15:0] v);
        @(negedge clk);
        iBin   = v;
        iStart = 1'b1;
        @(posedge clk);
        #1;
        iStart = 1'b0;
    endtask

    // Counts edges until oDONE is seen, bounded.
    task automatic waitDone(output int n);
        n = 0;
        while (!done0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic runConv(input logic [15:0] v, input string tag);
        int n;
        startPulse(v);
        checkVal({tag, "_busyStart"}, 32'(busy0), 32'd1);
        iBin = ~v;
        waitDone(n);
        checkVal({tag, "_latency"}, n, 32'd17);
        checkVal({tag, "_doneAll"}, {29'd0, done0, done1, done2}, 32'd7);
        checkVal({tag, "_busyAtDone"}, 32'(busy0), 32'd0);
        checkResults(32'(v));
        @(posedge clk);
        #1;
        checkVal({tag, "_donePulse"}, 32'(done0), 32'd0);
        checkResults(32'(v));
    endtask

    initial begin
        int n;
        int sawDone;
        logic [15:0] rv;

        rstN   = 1'b0;
        iStart = 1'b0;
        iBin   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("resetHeld");
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkReset("resetReleased");

        runConv(16'd65535, "max");
        runConv(16'd1000,  "thousand");
        runConv(16'd0,     "zero");
        runConv(16'd12345, "ovf4");
        runConv(16'd42,    "fortytwo");
        runConv(16'd9999,  "edge9999");
        runConv(16'd10000, "edge10000");
        runConv(16'd9,     "nine");
        runConv(16'd10,    "ten");

        // Starts during SHIFT and DONE are dropped; the next IDLE cycle accepts.
        startPulse(16'd1234);
        repeat (4) @(posedge clk);
        startPulse(16'd9);
        checkVal("ignore_busyMid", 32'(busy0), 32'd1);
        repeat (11) @(posedge clk);
        startPulse(16'd9);
        checkVal("ignore_doneAt17", 32'(done0), 32'd1);
        checkResults(32'd1234);
        startPulse(16'd9);
        checkVal("ignore_acceptAt18", 32'(busy0), 32'd1);
        waitDone(n);
        checkVal("ignore_latency2", n, 32'd17);
        checkResults(32'd9);
        @(posedge clk);

        // Reset in the middle of a conversion aborts without a DONE pulse.
        startPulse(16'd4321);
        repeat (7) @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        checkReset("abortReset");
        @(negedge clk);
        rstN = 1'b1;
        sawDone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done0 || done1 || done2) sawDone = 1;
        end
        checkVal("abort_noDone", sawDone, 32'd0);
        checkReset("abortIdle");
        runConv(16'd77, "afterAbort");

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0: rv = 16'($urandom_range(0, 99));
                1: rv = 16'($urandom_range(100, 9999));
                2: rv = 16'($urandom_range(10000, 65535));
                default: rv = 16'($urandom);
            endcase
            runConv(rv, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
